// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with runtime parity and stop-bit options
//
// Words enter a FIFO over a valid/ready handshake and are serialised LSB-first:
// start bit, DATA_W data bits, optional parity bit, then 1 or 2 stop bits.
// Every line bit lasts max(clock_per_bit,1) clk cycles. Frames run back-to-back
// while the FIFO holds data.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   clock_per_bit  clk cycles per serial bit (0 behaves as 1)
//   parity_mode    00 none, 01 even, 10 odd, 11 none
//   two_stop       0 = one stop bit, 1 = two stop bits
//   data_i         word to transmit
//   valid_i        data_i valid
//   ready_o        FIFO can accept a word (not full)
//   tx_o           serial line, idle high
//   busy_o         frame in progress or FIFO non-empty (registered)
//   tx_done_tick_o one-cycle pulse during the last cycle of each frame
//   fifo_count_o   occupied FIFO entries
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CNT_W-1:0]              clock_per_bit,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          tx_done_tick_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [DATA_W-1:0]   r_shreg;
    logic [BW-1:0]       r_bit_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_pm1;        // latched bit period minus one
    logic                r_par_en;
    logic                r_par_bit;
    logic                r_two_stop;
    logic                r_stop_idx;
    logic                r_tx;
    logic                r_busy;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_bit_end;
    logic                w_last_data;
    logic                w_last_stop;
    logic                w_shift;
    logic                w_tx_nxt;
    logic                w_done;
    logic [CW-1:0]       w_count_nxt;

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_push      = valid_i && !w_full;
    assign w_bit_end   = (r_cnt == r_pm1);
    assign w_last_data = (r_bit_idx == BW'(DATA_W - 1));
    assign w_last_stop = (r_stop_idx == r_two_stop);
    // The start bit and every non-final data bit hand the next data bit to the line.
    assign w_shift     = w_bit_end && ((r_state == S_START) ||
                                       ((r_state == S_DATA) && !w_last_data));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = r_tx;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx_nxt    = r_shreg[0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (!w_last_data) begin
                        w_tx_nxt = r_shreg[0];
                    end else if (r_par_en) begin
                        w_tx_nxt    = r_par_bit;
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_done = 1'b1;
                    if (r_count != '0) begin
                        // Chain straight into the next start bit, no idle cycle.
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array carries no reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_cnt      <= '0;
            r_pm1      <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                // Frame configuration is frozen here until the next pop.
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_shreg    <= r_mem[r_rd_ptr];
                r_cnt      <= '0;
                r_pm1      <= (clock_per_bit == '0) ? '0 : clock_per_bit - CNT_W'(1);
                r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_par_bit  <= (^r_mem[r_rd_ptr]) ^ parity_mode[1];
                r_two_stop <= two_stop;
            end else begin
                if (r_state != S_IDLE) begin
                    r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
                end
                if (w_shift) begin
                    r_shreg <= r_shreg >> 1;
                end
            end
            if ((r_state == S_START) && w_bit_end) begin
                r_bit_idx <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_idx <= r_bit_idx + BW'(1);
            end
            if ((w_state_nxt == S_STOP) && (r_state != S_STOP)) begin
                r_stop_idx <= 1'b0;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                r_stop_idx <= 1'b1;
            end
        end
    end

    assign ready_o        = !w_full;
    assign tx_o           = r_tx;
    assign busy_o         = r_busy;
    assign tx_done_tick_o = w_done;
    assign fifo_count_o   = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] clock_per_bit = 16'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        valid_i = 1'b0;
    logic        ready_o, tx_o, busy_o, tx_done_tick_o;
    logic [3:0]  fifo_count_o;

    logic [4:0]  data5 = 5'h00;
    logic        valid5 = 1'b0;
    logic        ready5, tx5, busy5, tick5;
    logic [3:0]  count5;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clock_per_bit(clock_per_bit), .parity_mode(parity_mode),
        .two_stop(two_stop), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .tx_o(tx_o), .busy_o(busy_o), .tx_done_tick_o(tx_done_tick_o), .fifo_count_o(fifo_count_o)
    );

    uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut5 (
        .clk(clk), .rst(rst), .clock_per_bit(clock_per_bit), .parity_mode(parity_mode),
        .two_stop(two_stop), .data_i(data5), .valid_i(valid5), .ready_o(ready5),
        .tx_o(tx5), .busy_o(busy5), .tx_done_tick_o(tick5), .fifo_count_o(count5)
    );

    int total = 0;
    int bad = 0;
    int idle_err = 0;
    int stat_err = 0;
    int maxcnt = 0;
    int ready_low = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] cfg_p_cpb;
    logic [1:0]  cfg_p_pm;
    logic        cfg_p_ts;

    bit          in_frame = 1'b0;
    bit          start_due = 1'b0;
    int          idx = 0;
    int          flen = 0;
    int          ferr = 0;
    int          ferr_at = 0;
    int          fid = 0;
    logic [7:0]  fword;
    bit          frm [0:255];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected line waveform of one frame: start, data LSB-first, parity, stop(s),
    // each bit repeated for the bit period.
    function automatic int build(input logic [7:0] w, input logic [15:0] cpb,
                                 input logic [1:0] pm, input logic ts);
        int p;
        int n;
        bit bits[$];
        p = (cpb == 16'd0) ? 1 : int'(cpb);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (pm == 2'b01) bits.push_back(^w);
        else if (pm == 2'b10) bits.push_back(~^w);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        n = 0;
        foreach (bits[k]) begin
            for (int r = 0; r < p; r++) begin
                frm[n] = bits[k];
                n++;
            end
        end
        return n;
    endfunction

    // Input side: record accepted words and the configuration seen at each edge.
    always @(posedge clk) begin
        cfg_p_cpb <= clock_per_bit;
        cfg_p_pm  <= parity_mode;
        cfg_p_ts  <= two_stop;
        if (rst && valid_i && ready_o) exp_q.push_back(data_i);
    end

    // Output side: expect a frame whenever words are pending and the line is free.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            in_frame  = 1'b0;
            start_due = 1'b0;
        end else begin
            if (start_due) begin
                fword    = exp_q.pop_front();
                flen     = build(fword, cfg_p_cpb, cfg_p_pm, cfg_p_ts);
                in_frame = 1'b1;
                idx      = 0;
                ferr     = 0;
                fid++;
            end
            if (in_frame) begin
                if (tx_o !== frm[idx] || tx_done_tick_o !== (idx == flen - 1)) begin
                    if (ferr == 0) ferr_at = idx;
                    ferr++;
                end
            end else if (tx_o !== 1'b1 || tx_done_tick_o !== 1'b0) begin
                idle_err++;
            end
            if (busy_o !== (in_frame || exp_q.size() != 0) ||
                ready_o !== (exp_q.size() < DEPTH) ||
                fifo_count_o !== 4'(exp_q.size())) begin
                stat_err++;
            end
            if (int'(fifo_count_o) > maxcnt) maxcnt = int'(fifo_count_o);
            if (!ready_o) ready_low = 1;
            if (in_frame) begin
                idx++;
                if (idx == flen) begin
                    in_frame = 1'b0;
                    total++;
                    if (ferr != 0) begin
                        bad++;
                        $display("FAIL frame%0d word=%02h bad_cycles=%0d first_at=%0d required bad_cycles=0",
                                 fid, fword, ferr, ferr_at);
                    end
                end
            end
            start_due = !in_frame && (exp_q.size() != 0);
        end
    end

    task automatic push_word(input logic [7:0] d);
        int t;
        t = 0;
        data_i  = d;
        valid_i = 1'b1;
        while (!ready_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            total++;
            bad++;
            $display("FAIL push_timeout word=%02h waited=%0d required<2000", d, t);
        end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while ((busy_o || in_frame || exp_q.size() != 0) && t < 5000);
        check({name, "_idle"}, (t < 5000) ? 1 : 0, 1);
    endtask

    task automatic frame5(input logic [4:0] d, input logic [1:0] pm);
        int err;
        bit e;
        err = 0;
        clock_per_bit = 16'd0;
        parity_mode   = pm;
        two_stop      = 1'b0;
        data5         = d;
        valid5        = 1'b1;
        @(negedge clk);
        valid5 = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            if (n == 2) e = 1'b0;
            else if (n >= 3 && n <= 7) e = d[n-3];
            else e = 1'b1;
            if (tx5 !== e || tick5 !== (n == 8)) err++;
            @(negedge clk);
        end
        check("dw5_frame", err, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int fall;
        int tick_at;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_tick", tx_done_tick_o, 0);
        check("rst_count", fifo_count_o, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single 0xA5 frame, P=4, no parity, one stop bit.
        clock_per_bit = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
        push_word(8'hA5);
        t = 1; fall = 0; tick_at = 0;
        while (t < 200) begin
            if (tx_o == 1'b0 && fall == 0) fall = t;
            if (tx_done_tick_o) begin
                tick_at = t;
                break;
            end
            @(negedge clk);
            t++;
        end
        check("t1_fall", fall, 2);
        check("t1_tick", tick_at, 41);
        @(negedge clk);
        check("t1_busy_after", busy_o, 0);

        // Even then odd parity, two stop bits, P=2, back-to-back.
        clock_per_bit = 16'd2; two_stop = 1'b1; parity_mode = 2'b01;
        data_i = 8'h03; valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid_i = 1'b0; parity_mode = 2'b10;
        wait_idle("t2");

        // Ten words with valid held, P=3: FIFO fills and throttles.
        maxcnt = 0; ready_low = 0;
        clock_per_bit = 16'd3; parity_mode = 2'b00; two_stop = 1'b0;
        for (int i = 0; i < 10; i++) push_word(8'($urandom));
        wait_idle("t3");
        check("t3_maxcnt", maxcnt, 8);
        check("t3_ready_low", ready_low, 1);

        // Bit period change mid-frame applies to the next frame only.
        clock_per_bit = 16'd4;
        push_word(8'h5C);
        push_word(8'hE1);
        clock_per_bit = 16'd8;
        wait_idle("t4");

        // Reset during data bit 3 with three words still buffered.
        clock_per_bit = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!(in_frame && idx >= 17 && idx < 20) && t < 500);
        check("t5_reach_bit3", (t < 500) ? 1 : 0, 1);
        check("t5_count_before", fifo_count_o, 3);
        #2 rst = 1'b0;
        #1;
        check("t5_tx", tx_o, 1);
        check("t5_count", fifo_count_o, 0);
        check("t5_busy", busy_o, 0);
        check("t5_ready", ready_o, 1);
        check("t5_tick", tx_done_tick_o, 0);
        @(negedge clk);
        @(negedge clk);
        check("t5_tick_held", tx_done_tick_o, 0);
        rst = 1'b1;
        @(negedge clk);
        parity_mode = 2'b10;
        push_word(8'h96);
        wait_idle("t5_after");

        // Random words, gaps and configuration.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                clock_per_bit = 16'($urandom_range(0, 5));
                parity_mode   = 2'($urandom_range(0, 3));
                two_stop      = 1'($urandom_range(0, 1));
            end
            repeat ($urandom_range(0, 12)) @(negedge clk);
            push_word(8'($urandom));
        end
        wait_idle("rand");

        // DATA_W=5 with a zero bit period: 7-cycle frames.
        frame5(5'h15, 2'b00);
        frame5(5'($urandom), 2'b11);
        frame5(5'($urandom), 2'b00);
        check("dw5_busy", busy5, 0);
        check("dw5_count", count5, 0);
        check("dw5_ready", ready5, 1);

        check("idle_line", idle_err, 0);
        check("status", stat_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
